// File: rtl/cpu_fetch.sv
// Instruction fetch stage: pipelined bus requests with credit-limited
// issue, in-order response queue and redirect with stale-ack discard.
module cpu_fetch #(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              inst_cyc_out,
    output logic              inst_stb_out,
    output logic [ADDR_W-1:0] inst_addr_out,
    input  logic              inst_stall_in,
    input  logic              inst_ack_in,
    input  logic [31:0]       inst_data_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_addr_in,
    output logic              fetch_valid_out,
    input  logic              fetch_ready_in,
    output logic [31:0]       fetch_inst_out,
    output logic [ADDR_W-1:0] fetch_pc_out,
    output logic [ADDR_W-1:0] fetch_pc_next_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [CW-1:0]     out_q;
    logic [CW-1:0]     disc_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wr_q;
    logic [PW-1:0]     rd_q;

    logic [31:0]       inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [CW:0]       credit;
    logic              stb;
    logic              accept;
    logic              ack_v;
    logic              push;
    logic              pop;
    logic              valid;
    logic [CW-1:0]     out_nx;
    logic [ADDR_W-1:0] redir_pc;
    logic [1:0]        unused_addr_bits;

    assign unused_addr_bits = redirect_addr_in[1:0];
    assign redir_pc = {redirect_addr_in[ADDR_W-1:2], 2'b00};

    // Outstanding requests reserve queue slots, so an ack always fits.
    assign credit = {1'b0, out_q} + {1'b0, count_q};
    assign stb    = !sys_rst && (credit < (CW+1)'(DEPTH));
    assign accept = stb && !inst_stall_in;
    assign ack_v  = !sys_rst && inst_ack_in && (out_q != '0);
    assign push   = ack_v && (disc_q == '0) && !redirect_in;
    assign valid  = !sys_rst && (count_q != '0);
    assign pop    = valid && fetch_ready_in && !redirect_in;
    assign out_nx = out_q + CW'(accept) - CW'(ack_v);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_q    <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            disc_q    <= '0;
            count_q   <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
        end else begin
            out_q <= out_nx;
            if (redirect_in) begin
                addr_q    <= redir_pc;
                resp_pc_q <= redir_pc;
                disc_q    <= out_nx;
                count_q   <= '0;
                wr_q      <= '0;
                rd_q      <= '0;
            end else begin
                if (accept)
                    addr_q <= addr_q + ADDR_W'(4);
                if (push)
                    resp_pc_q <= resp_pc_q + ADDR_W'(4);
                if (ack_v && (disc_q != '0))
                    disc_q <= disc_q - CW'(1);
                if (push)
                    wr_q <= wr_q + PW'(1);
                if (pop)
                    rd_q <= rd_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            inst_mem[wr_q] <= inst_data_in;
            pc_mem[wr_q]   <= resp_pc_q;
        end
    end

    assign inst_stb_out      = stb;
    assign inst_cyc_out      = stb || (!sys_rst && (out_q != '0));
    assign inst_addr_out     = sys_rst ? RESET_PC : addr_q;
    assign fetch_valid_out   = valid;
    assign fetch_inst_out    = valid ? inst_mem[rd_q] : '0;
    assign fetch_pc_out      = valid ? pc_mem[rd_q] : '0;
    assign fetch_pc_next_out = fetch_pc_out + ADDR_W'(4);

endmodule

// File: tb/tb_cpu_fetch.sv
// Scoreboard bench for cpu_fetch: bus responder, pop monitor and
// directed scenarios for streaming, backpressure, stall, redirect, reset.
module tb_cpu_fetch;

    localparam int          AW   = 32;
    localparam int          D    = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        inst_cyc_out;
    logic        inst_stb_out;
    logic [31:0] inst_addr_out;
    logic        inst_stall_in;
    logic        inst_ack_in;
    logic [31:0] inst_data_in;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        fetch_valid_out;
    logic        fetch_ready_in;
    logic [31:0] fetch_inst_out;
    logic [31:0] fetch_pc_out;
    logic [31:0] fetch_pc_next_out;

    logic        ack_r = 1'b0;
    logic [31:0] data_r = '0;
    logic        late_ack;
    logic        ack_en;
    logic        drop_pend;

    int tests = 0;
    int fails = 0;
    int acc;
    int vcnt;

    logic [31:0] exp_q  [$];
    logic [31:0] pend_q [$];

    always #5 sys_clk = ~sys_clk;

    assign inst_ack_in  = ack_r | late_ack;
    assign inst_data_in = late_ack ? 32'hBAD0_BAD0 : data_r;

    cpu_fetch #(.ADDR_W(AW), .DEPTH(D), .RESET_PC(RPC)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .inst_cyc_out(inst_cyc_out),
        .inst_stb_out(inst_stb_out),
        .inst_addr_out(inst_addr_out),
        .inst_stall_in(inst_stall_in),
        .inst_ack_in(inst_ack_in),
        .inst_data_in(inst_data_in),
        .redirect_in(redirect_in),
        .redirect_addr_in(redirect_addr_in),
        .fetch_valid_out(fetch_valid_out),
        .fetch_ready_in(fetch_ready_in),
        .fetch_inst_out(fetch_inst_out),
        .fetch_pc_out(fetch_pc_out),
        .fetch_pc_next_out(fetch_pc_next_out)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 60) begin
            @(negedge sys_clk);
            n++;
        end
        repeat (2) @(negedge sys_clk);
        check(name, exp_q.size(), 0);
    endtask

    // Slave: one-cycle ack latency, in order, holdable via ack_en.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (drop_pend)
                pend_q.delete();
            if (ack_en && pend_q.size() > 0) begin
                ack_r  = 1'b1;
                data_r = inst_of(pend_q.pop_front());
            end else begin
                ack_r  = 1'b0;
            end
            @(negedge sys_clk);
            if (!sys_rst && inst_stb_out && !inst_stall_in)
                pend_q.push_back(inst_addr_out);
        end
    end

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && fetch_valid_out && fetch_ready_in && !redirect_in) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_unexpected: got pc %h, required no entry",
                             fetch_pc_out);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", fetch_pc_out, e);
                    check("pop_inst", fetch_inst_out, inst_of(e));
                    check("pop_pc_next", fetch_pc_next_out, e + 32'd4);
                end
            end
        end
    end

    initial begin
        sys_rst          = 1'b1;
        inst_stall_in    = 1'b0;
        fetch_ready_in   = 1'b1;
        redirect_in      = 1'b0;
        redirect_addr_in = '0;
        late_ack         = 1'b0;
        ack_en           = 1'b1;
        drop_pend        = 1'b0;

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst0_stb", inst_stb_out, 0);
        check("rst0_cyc", inst_cyc_out, 0);
        check("rst0_addr", inst_addr_out, RPC);
        check("rst0_valid", fetch_valid_out, 0);
        check("rst0_inst", fetch_inst_out, 0);
        check("rst0_pc", fetch_pc_out, 0);

        // streaming
        for (int a = 0; a < 32; a += 4)
            exp_q.push_back(a);
        tick;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("c0_stb", inst_stb_out, 1);
        check("c0_cyc", inst_cyc_out, 1);
        check("c0_addr", inst_addr_out, RPC);
        vcnt = 0;
        for (int i = 1; i <= 9; i++) begin
            tick;
            if (i == 8)
                inst_stall_in = 1'b1;
            @(negedge sys_clk);
            if (i >= 2 && fetch_valid_out)
                vcnt++;
        end
        check("stream_valid_cycles", vcnt, 8);
        wait_drain("stream_drain");
        check("stream_next_addr", inst_addr_out, 32'h20);

        // backpressure
        for (int a = 32'h20; a < 32'h30; a += 4)
            exp_q.push_back(a);
        acc = 0;
        tick;
        fetch_ready_in = 1'b0;
        inst_stall_in  = 1'b0;
        @(negedge sys_clk);
        if (inst_stb_out)
            acc++;
        for (int i = 1; i < 8; i++) begin
            tick;
            @(negedge sys_clk);
            if (inst_stb_out)
                acc++;
        end
        check("bp_accepts", acc, 4);
        check("bp_stb_off", inst_stb_out, 0);
        check("bp_cyc_off", inst_cyc_out, 0);
        check("bp_valid", fetch_valid_out, 1);
        tick;
        fetch_ready_in = 1'b1;
        @(negedge sys_clk);
        tick;
        fetch_ready_in = 1'b0;
        inst_stall_in  = 1'b1;
        @(negedge sys_clk);
        check("bp_stb_reenable", inst_stb_out, 1);
        check("bp_addr", inst_addr_out, 32'h30);
        tick;
        fetch_ready_in = 1'b1;
        wait_drain("bp_drain");

        // stall hold at 0x10
        tick;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h10;
        @(negedge sys_clk);
        for (int k = 0; k < 5; k++) begin
            tick;
            redirect_in = 1'b0;
            @(negedge sys_clk);
            check("stall_stb", inst_stb_out, 1);
            check("stall_addr", inst_addr_out, 32'h10);
        end
        exp_q.push_back(32'h10);
        tick;
        inst_stall_in = 1'b0;
        @(negedge sys_clk);
        check("stall_release_addr", inst_addr_out, 32'h10);
        tick;
        inst_stall_in = 1'b1;
        @(negedge sys_clk);
        check("stall_next_addr", inst_addr_out, 32'h14);
        wait_drain("stall_drain");

        // redirect with 3 outstanding
        tick;
        ack_en        = 1'b0;
        inst_stall_in = 1'b0;
        @(negedge sys_clk);
        repeat (2) begin
            tick;
            @(negedge sys_clk);
        end
        tick;
        inst_stall_in    = 1'b1;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h103;
        @(negedge sys_clk);
        check("rd_stb_3out", inst_stb_out, 1);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick;
        redirect_in   = 1'b0;
        inst_stall_in = 1'b0;
        ack_en        = 1'b1;
        @(negedge sys_clk);
        check("rd_addr", inst_addr_out, 32'h100);
        check("rd_valid_flush", fetch_valid_out, 0);
        tick;
        @(negedge sys_clk);
        tick;
        inst_stall_in = 1'b1;
        @(negedge sys_clk);
        wait_drain("rd_drain");

        // redirect coincident with ack, accept and pop
        tick;
        fetch_ready_in = 1'b0;
        inst_stall_in  = 1'b0;
        @(negedge sys_clk);
        tick;
        @(negedge sys_clk);
        tick;
        fetch_ready_in   = 1'b1;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h200;
        @(negedge sys_clk);
        check("co_valid_before", fetch_valid_out, 1);
        check("co_stb", inst_stb_out, 1);
        exp_q.push_back(32'h200);
        tick;
        redirect_in = 1'b0;
        @(negedge sys_clk);
        check("co_valid_flush", fetch_valid_out, 0);
        check("co_addr", inst_addr_out, 32'h200);
        tick;
        inst_stall_in = 1'b1;
        @(negedge sys_clk);
        wait_drain("co_drain");

        // address wrap
        tick;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'hFFFF_FFFE;
        @(negedge sys_clk);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick;
        redirect_in   = 1'b0;
        inst_stall_in = 1'b0;
        @(negedge sys_clk);
        check("wrap_addr_top", inst_addr_out, 32'hFFFF_FFFC);
        tick;
        @(negedge sys_clk);
        check("wrap_addr_zero", inst_addr_out, 32'h0);
        tick;
        inst_stall_in = 1'b1;
        @(negedge sys_clk);
        wait_drain("wrap_drain");

        // reset mid-burst with 2 outstanding
        redirect_addr_in = 32'h204;
        tick;
        redirect_in = 1'b1;
        @(negedge sys_clk);
        tick;
        redirect_in   = 1'b0;
        ack_en        = 1'b0;
        inst_stall_in = 1'b0;
        @(negedge sys_clk);
        tick;
        @(negedge sys_clk);
        tick;
        sys_rst       = 1'b1;
        inst_stall_in = 1'b1;
        drop_pend     = 1'b1;
        @(negedge sys_clk);
        check("mrst_stb", inst_stb_out, 0);
        check("mrst_cyc", inst_cyc_out, 0);
        check("mrst_addr", inst_addr_out, RPC);
        check("mrst_valid", fetch_valid_out, 0);
        check("mrst_pc", fetch_pc_out, 0);
        check("mrst_inst", fetch_inst_out, 0);
        tick;
        @(negedge sys_clk);
        tick;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("mrst_rel_stb", inst_stb_out, 1);
        check("mrst_rel_cyc", inst_cyc_out, 1);
        check("mrst_rel_addr", inst_addr_out, RPC);
        tick;
        late_ack = 1'b1;
        @(negedge sys_clk);
        tick;
        @(negedge sys_clk);
        tick;
        late_ack = 1'b0;
        @(negedge sys_clk);
        check("late_ack_valid", fetch_valid_out, 0);
        exp_q.push_back(RPC);
        tick;
        drop_pend     = 1'b0;
        ack_en        = 1'b1;
        inst_stall_in = 1'b0;
        @(negedge sys_clk);
        tick;
        inst_stall_in = 1'b1;
        @(negedge sys_clk);
        check("mrst_next_addr", inst_addr_out, RPC + 32'd4);
        wait_drain("mrst_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
